// File: rtl/mips32_pipe_core.sv
// mips32_pipe_core -- five-stage (IF/ID/EX/MEM/WB) MIPS32-subset core.
//
// Single rising-edge clock, asynchronous active-low reset. Hazards are
// resolved by a hardware interlock. Taken branches are resolved in EX and
// flush IF/ID and ID/EX. HLT stops fetch and, once it retires, sets a
// sticky halted flag.
//
// Optional build macro:
//   MIPS_FWD_EN  - forward EX/MEM and MEM/WB results into EX so that only
//                  load-use dependences stall (1 cycle). Without it, ID waits
//                  until the producer has reached WB (2 stall cycles).
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset; control state only
//   imem_we     instruction memory write strobe (honoured at any time)
//   imem_waddr  instruction memory write address
//   imem_wdata  instruction word to write
//   dbg_raddr   register debug read address
//   dbg_rdata   combinational register read, R0 reads 0
//   pc          current fetch PC (word address)
//   halted      sticky, set when HLT retires
//   instret     retired non-bubble instruction count, wraps
module mips32_pipe_core #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic [$clog2(NREG)-1:0]       dbg_raddr,
  output logic [XLEN-1:0]               dbg_rdata,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          halted,
  output logic [31:0]                   instret
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int RAW = $clog2(NREG);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  // Results wrap modulo 2^XLEN; MUL keeps the low XLEN bits.
  function automatic logic [XLEN-1:0] alu_f(input logic [5:0]             op,
                                            input logic signed [XLEN-1:0] a,
                                            input logic signed [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: r = a + b;
      OP_SUB, OP_SUBI:               r = a - b;
      OP_AND:                        r = a & b;
      OP_OR:                         r = a | b;
      OP_SLT, OP_SLTI:               r = (a < b) ? XLEN'(1) : '0;
      OP_MUL:                        r = a * b;
      default:                       r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext16_f(input logic signed [15:0] v);
    return XLEN'(v);
  endfunction

  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] regs [NREG];

  // IF/ID
  logic [31:0]     ir_p0;
  logic [IAW-1:0]  npc_p0;
  logic            vld_p0;
  // ID/EX
  logic [5:0]      op_p1;
  logic [RAW-1:0]  rs_p1, rt_p1, dst_p1;
  logic [XLEN-1:0] a_p1, b_p1, imm_p1;
  logic [IAW-1:0]  npc_p1;
  logic            rr_p1, wr_p1, ld_p1, st_p1, br_p1, hlt_p1, vld_p1;
  // EX/MEM
  logic [XLEN-1:0] alu_p2, sd_p2;
  logic [RAW-1:0]  dst_p2;
  logic            wr_p2, ld_p2, st_p2, hlt_p2, vld_p2;
  // MEM/WB
  logic [XLEN-1:0] alu_p3, lmd_p3;
  logic [RAW-1:0]  dst_p3;
  logic            wr_p3, ld_p3, hlt_p3, vld_p3;

  // ---------------- ID: decode, register read, interlock ----------------
  logic [5:0]      op_id;
  logic [RAW-1:0]  rs_id, rt_id, rd_id, dst_id;
  logic            legal_id, rr_id, wr_id, ld_id, st_id, br_id, hlt_id;
  logic            use_rs_id, use_rt_id;
  logic [XLEN-1:0] rs_val_id, rt_val_id, imm_id;
  logic [XLEN-1:0] wb_val;
  logic            wb_we;
  logic            stall, freeze, br_taken;
  logic [IAW-1:0]  br_target;

  assign op_id  = ir_p0[31:26];
  assign rs_id  = ir_p0[21 +: RAW];
  assign rt_id  = ir_p0[16 +: RAW];
  assign rd_id  = ir_p0[11 +: RAW];
  assign imm_id = sext16_f(ir_p0[15:0]);

  always_comb begin
    legal_id  = 1'b0;
    rr_id     = 1'b0;
    wr_id     = 1'b0;
    ld_id     = 1'b0;
    st_id     = 1'b0;
    br_id     = 1'b0;
    hlt_id    = 1'b0;
    use_rs_id = 1'b0;
    use_rt_id = 1'b0;
    dst_id    = rt_id;
    case (op_id)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        legal_id = 1'b1; rr_id = 1'b1; wr_id = 1'b1; dst_id = rd_id;
        use_rs_id = 1'b1; use_rt_id = 1'b1;
      end
      OP_LW: begin
        legal_id = 1'b1; wr_id = 1'b1; ld_id = 1'b1; use_rs_id = 1'b1;
      end
      OP_SW: begin
        legal_id = 1'b1; st_id = 1'b1; use_rs_id = 1'b1; use_rt_id = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_SLTI: begin
        legal_id = 1'b1; wr_id = 1'b1; use_rs_id = 1'b1;
      end
      OP_BNEQZ, OP_BEQZ: begin
        legal_id = 1'b1; br_id = 1'b1; use_rs_id = 1'b1;
      end
      OP_HLT: begin
        legal_id = 1'b1; hlt_id = 1'b1;
      end
      default: ;
    endcase
  end

  assign wb_val = ld_p3 ? lmd_p3 : alu_p3;
  assign wb_we  = vld_p3 && wr_p3 && (dst_p3 != '0);

  // Write-through: a register written this cycle by WB is read with its new value.
  always_comb begin
    rs_val_id = regs[rs_id];
    rt_val_id = regs[rt_id];
    if (wb_we && dst_p3 == rs_id) rs_val_id = wb_val;
    if (wb_we && dst_p3 == rt_id) rt_val_id = wb_val;
    if (rs_id == '0) rs_val_id = '0;
    if (rt_id == '0) rt_val_id = '0;
  end

  logic hz_rs_p1, hz_rt_p1, hz_rs_p2, hz_rt_p2;
  assign hz_rs_p1 = use_rs_id && (rs_id != '0) && (rs_id == dst_p1);
  assign hz_rt_p1 = use_rt_id && (rt_id != '0) && (rt_id == dst_p1);
  assign hz_rs_p2 = use_rs_id && (rs_id != '0) && (rs_id == dst_p2);
  assign hz_rt_p2 = use_rt_id && (rt_id != '0) && (rt_id == dst_p2);

`ifdef MIPS_FWD_EN
  // A load's data only exists after MEM, so its consumer waits one cycle.
  assign stall = vld_p0 && legal_id && vld_p1 && ld_p1 && (hz_rs_p1 || hz_rt_p1);
`else
  // Wait until the producer reaches WB, where write-through supplies it.
  assign stall = vld_p0 && legal_id &&
                 ((vld_p1 && wr_p1 && (hz_rs_p1 || hz_rt_p1)) ||
                  (vld_p2 && wr_p2 && (hz_rs_p2 || hz_rt_p2)));
`endif

  // Fetch stops while any HLT is in flight and stays stopped once halted.
  assign freeze = halted || (vld_p0 && hlt_id) || (vld_p1 && hlt_p1) ||
                  (vld_p2 && hlt_p2) || (vld_p3 && hlt_p3);

  // ---------------- EX: operand select, ALU, branch resolve ----------------
  logic [XLEN-1:0] ex_a, ex_b, ex_opb, alu_ex;

`ifdef MIPS_FWD_EN
  // The younger EX/MEM result overrides MEM/WB. Loads never forward from
  // EX/MEM; the interlock keeps their consumers out of EX until MEM/WB.
  always_comb begin
    ex_a = a_p1;
    ex_b = b_p1;
    if (rs_p1 != '0 && vld_p3 && wr_p3 && dst_p3 == rs_p1) ex_a = wb_val;
    if (rt_p1 != '0 && vld_p3 && wr_p3 && dst_p3 == rt_p1) ex_b = wb_val;
    if (rs_p1 != '0 && vld_p2 && wr_p2 && !ld_p2 && dst_p2 == rs_p1) ex_a = alu_p2;
    if (rt_p1 != '0 && vld_p2 && wr_p2 && !ld_p2 && dst_p2 == rt_p1) ex_b = alu_p2;
  end
`else
  assign ex_a = a_p1;
  assign ex_b = b_p1;
`endif

  assign ex_opb    = rr_p1 ? ex_b : imm_p1;
  assign alu_ex    = alu_f(op_p1, ex_a, ex_opb);
  assign br_taken  = vld_p1 && br_p1 && ((op_p1 == OP_BEQZ) == (ex_a == '0));
  assign br_target = npc_p1 + imm_p1[IAW-1:0];

  // ---------------- control state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      halted  <= 1'b0;
      instret <= '0;
    end else begin
      // A taken branch overrides both the stall and the HLT freeze.
      if (br_taken) begin
        pc     <= br_target;
        vld_p0 <= 1'b0;
      end else if (stall) begin
        pc     <= pc;
        vld_p0 <= vld_p0;
      end else if (freeze) begin
        pc     <= pc;
        vld_p0 <= 1'b0;
      end else begin
        pc     <= pc + 1'b1;
        vld_p0 <= 1'b1;
      end
      vld_p1 <= !(br_taken || stall) && vld_p0 && legal_id;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      if (vld_p3) instret <= instret + 32'd1;
      if (vld_p3 && hlt_p3) halted <= 1'b1;
    end
  end

  // ---------------- IF -> IF/ID ----------------
  always_ff @(posedge clk) begin
    if (!stall) begin
      ir_p0  <= imem[pc];
      npc_p0 <= pc + 1'b1;
    end
  end

  // ---------------- ID -> ID/EX ----------------
  always_ff @(posedge clk) begin
    op_p1  <= op_id;
    rs_p1  <= rs_id;
    rt_p1  <= rt_id;
    dst_p1 <= dst_id;
    a_p1   <= rs_val_id;
    b_p1   <= rt_val_id;
    imm_p1 <= imm_id;
    npc_p1 <= npc_p0;
    rr_p1  <= rr_id;
    wr_p1  <= wr_id;
    ld_p1  <= ld_id;
    st_p1  <= st_id;
    br_p1  <= br_id;
    hlt_p1 <= hlt_id;
  end

  // ---------------- EX -> EX/MEM ----------------
  always_ff @(posedge clk) begin
    alu_p2 <= alu_ex;
    sd_p2  <= ex_b;
    dst_p2 <= dst_p1;
    wr_p2  <= wr_p1;
    ld_p2  <= ld_p1;
    st_p2  <= st_p1;
    hlt_p2 <= hlt_p1;
  end

  // ---------------- MEM -> MEM/WB ----------------
  always_ff @(posedge clk) begin
    if (vld_p2 && st_p2) dmem[alu_p2[DAW-1:0]] <= sd_p2;
    alu_p3 <= alu_p2;
    lmd_p3 <= dmem[alu_p2[DAW-1:0]];
    dst_p3 <= dst_p2;
    wr_p3  <= wr_p2;
    ld_p3  <= ld_p2;
    hlt_p3 <= hlt_p2;
  end

  // ---------------- WB ----------------
  always_ff @(posedge clk) begin
    if (wb_we) regs[dst_p3] <= wb_val;
  end

  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];

  // Instruction bits outside the decoded fields, and the EX source indices
  // in the non-forwarding build, are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{ir_p0, rs_p1, rt_p1};

endmodule

// File: tb/tb_mips32_pipe_core.sv
module tb_mips32_pipe_core;

  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02,
                         OP_OR = 6'h03, OP_SLT = 6'h04, OP_MUL = 6'h05,
                         OP_LW = 6'h08, OP_SW = 6'h09, OP_ADDI = 6'h0A,
                         OP_SUBI = 6'h0B, OP_SLTI = 6'h0C, OP_BNEQZ = 6'h0D,
                         OP_HLT = 6'h3F;

`ifdef MIPS_FWD_EN
  localparam int E_T1 = 8,  E_T3 = 9,  E_LA = 15;
`else
  localparam int E_T1 = 12, E_T3 = 10, E_LA = 21;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_we = 1'b0;
  logic [9:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata;
  logic [9:0]  pc;
  logic        halted;
  logic [31:0] instret;

  logic        imem_we16 = 1'b0;
  logic [5:0]  imem_waddr16 = '0;
  logic [31:0] imem_wdata16 = '0;
  logic [3:0]  dbg_raddr16 = '0;
  logic [15:0] dbg_rdata16;
  logic [5:0]  pc16;
  logic        halted16;
  logic [31:0] instret16;

  mips32_pipe_core dut (
    .clk(clk), .rst_n(rst_n), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .pc(pc), .halted(halted), .instret(instret)
  );

  mips32_pipe_core #(.XLEN(16), .NREG(16), .IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut16 (
    .clk(clk), .rst_n(rst_n), .imem_we(imem_we16), .imem_waddr(imem_waddr16),
    .imem_wdata(imem_wdata16), .dbg_raddr(dbg_raddr16), .dbg_rdata(dbg_rdata16),
    .pc(pc16), .halted(halted16), .instret(instret16)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] prog [32];
  int plen = 0;
  int he;

  function automatic logic [31:0] enc_r(logic [5:0] op, int d, int s, int t);
    logic [4:0] dd, ss, tt;
    dd = d[4:0]; ss = s[4:0]; tt = t[4:0];
    return {op, ss, tt, dd, 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int t, int s, int imm);
    logic [4:0]  ss, tt;
    logic [15:0] ii;
    ss = s[4:0]; tt = t[4:0]; ii = imm[15:0];
    return {op, ss, tt, ii};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
    dbg_raddr = idx[4:0];
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  task automatic chk_reg16(input string tag, input int idx, input logic [31:0] exp);
    dbg_raddr16 = idx[3:0];
    #1;
    check(tag, {16'h0, dbg_rdata16}, exp);
  endtask

  task automatic put(input logic [31:0] w);
    prog[plen] = w;
    plen++;
  endtask

  task automatic load_prog();
    for (int k = 0; k < plen; k++) begin
      imem_we = 1'b1;
      imem_waddr = k[9:0];
      imem_wdata = prog[k];
      @(negedge clk);
    end
    imem_we = 1'b0;
  endtask

  task automatic wait_halt(output int e_out);
    e_out = 0;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk);
      #1;
      if (halted) begin
        e_out = e;
        break;
      end
    end
  endtask

  // Reset, load the current program, release reset at a falling edge and
  // count rising edges until halted (0 if the budget runs out).
  task automatic run_prog(output int e_out);
    @(negedge clk);
    rst_n = 1'b0;
    load_prog();
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt(e_out);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #20;
    check("reset_pc", {22'h0, pc}, 32'h0);
    check("reset_halted", {31'h0, halted}, 32'h0);
    check("reset_instret", instret, 32'h0);

    // 16-bit core program, loaded once; it reruns after every reset.
    plen = 0;
    put(enc_i(OP_ADDI, 1, 0, -1));
    put(enc_i(OP_ADDI, 2, 0, 1));
    put(enc_i(OP_ADDI, 4, 0, 16'h0100));
    put(enc_i(OP_ADDI, 5, 0, 16'h0100));
    put(enc_r(OP_ADD, 3, 1, 2));
    put(enc_r(OP_MUL, 6, 4, 5));
    put(enc_r(OP_SUB, 7, 0, 2));
    put(enc_r(OP_HLT, 0, 0, 0));
    for (int k = 0; k < plen; k++) begin
      imem_we16 = 1'b1;
      imem_waddr16 = k[5:0];
      imem_wdata16 = prog[k];
      @(negedge clk);
    end
    imem_we16 = 1'b0;

    // Setup: registers survive reset, so later programs rely on these.
    plen = 0;
    put(enc_i(OP_ADDI, 2, 0, 6));
    put(enc_i(OP_ADDI, 3, 0, 4));
    put(enc_i(OP_ADDI, 1, 0, 3));
    put(enc_i(OP_ADDI, 13, 0, 85));
    put(enc_i(OP_ADDI, 14, 0, 85));
    put(enc_i(OP_ADDI, 21, 0, 85));
    put(enc_r(OP_HLT, 0, 0, 0));
    run_prog(he);
    check("setup_halt_edge", he, 32'd11);
    chk_reg("setup_r2", 2, 32'd6);
    chk_reg("setup_r3", 3, 32'd4);

    // Dependent RR chain.
    plen = 0;
    put(enc_r(OP_ADD, 5, 2, 3));
    put(enc_r(OP_SUB, 7, 5, 3));
    put(enc_r(OP_MUL, 9, 7, 3));
    put(enc_r(OP_HLT, 0, 0, 0));
    run_prog(he);
    check("t1_halt_edge", he, E_T1);
    check("t1_instret", instret, 32'd4);
    chk_reg("t1_r5", 5, 32'd10);
    chk_reg("t1_r7", 7, 32'd6);
    chk_reg("t1_r9", 9, 32'd24);

    // Immediates, logic ops, signed compares, R0 write dropped.
    plen = 0;
    put(enc_i(OP_SUBI, 19, 0, 1));
    put(enc_i(OP_ADDI, 11, 2, 3));
    put(enc_i(OP_SLTI, 13, 2, 3));
    put(enc_i(OP_SLTI, 14, 0, -1));
    put(enc_i(OP_SLTI, 15, 2, 7));
    put(enc_r(OP_AND, 16, 2, 3));
    put(enc_r(OP_OR, 17, 2, 3));
    put(enc_r(OP_SLT, 18, 3, 2));
    put(enc_i(OP_ADDI, 0, 0, 5));
    put(enc_r(OP_SLT, 20, 19, 0));
    put(enc_r(OP_ADD, 21, 0, 0));
    put(enc_r(OP_HLT, 0, 0, 0));
    run_prog(he);
    check("t2_halt_edge", he, 32'd16);
    check("t2_instret", instret, 32'd12);
    chk_reg("t2_r19", 19, 32'hFFFF_FFFF);
    chk_reg("t2_r11", 11, 32'd9);
    chk_reg("t2_r13", 13, 32'd0);
    chk_reg("t2_r14", 14, 32'd0);
    chk_reg("t2_r15", 15, 32'd1);
    chk_reg("t2_r16", 16, 32'd4);
    chk_reg("t2_r17", 17, 32'd6);
    chk_reg("t2_r18", 18, 32'd1);
    chk_reg("t2_r20", 20, 32'd1);
    chk_reg("t2_r21", 21, 32'd0);
    chk_reg("t2_r0", 0, 32'd0);

    // Store, load, load-use.
    plen = 0;
    put(enc_i(OP_SW, 3, 0, 1));
    put(enc_i(OP_LW, 4, 0, 1));
    put(enc_r(OP_ADD, 6, 4, 4));
    put(enc_r(OP_HLT, 0, 0, 0));
    run_prog(he);
    check("t3_halt_edge", he, E_T3);
    chk_reg("t3_r4", 4, 32'd4);
    chk_reg("t3_r6", 6, 32'd8);

    // Restore R1=3 and run the countdown loop with HLT behind the branch.
    plen = 0;
    put(enc_i(OP_ADDI, 1, 0, 3));
    put(enc_r(OP_HLT, 0, 0, 0));
    run_prog(he);
    check("restore_halt_edge", he, 32'd6);
    plen = 0;
    put(enc_i(OP_SUBI, 1, 1, 1));
    put(enc_i(OP_BNEQZ, 0, 1, -2));
    put(enc_r(OP_HLT, 0, 0, 0));
    run_prog(he);
    check("loopa_halt_edge", he, E_LA);
    check("loopa_instret", instret, 32'd7);
    chk_reg("loopa_r1", 1, 32'd0);

    // Self-initialising loop, then reset in the middle and rerun.
    plen = 0;
    put(enc_i(OP_ADDI, 1, 0, 3));
    put(enc_i(OP_SUBI, 1, 1, 1));
    put(enc_i(OP_BNEQZ, 0, 1, -2));
    put(enc_r(OP_HLT, 0, 0, 0));
    run_prog(he);
    check("loopb_halted", {31'h0, halted}, 32'h1);
    check("loopb_instret", instret, 32'd8);
    chk_reg("loopb_r1", 1, 32'd0);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_pc", {22'h0, pc}, 32'h0);
    check("midrst_instret", instret, 32'h0);
    check("midrst_halted", {31'h0, halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt(he);
    check("rerun_halted", {31'h0, halted}, 32'h1);
    check("rerun_instret", instret, 32'd8);
    chk_reg("rerun_r1", 1, 32'd0);

    // 16-bit core ran alongside and has long since halted.
    check("x16_halted", {31'h0, halted16}, 32'h1);
    check("x16_instret", instret16, 32'd8);
    chk_reg16("x16_r1", 1, 32'h0000_FFFF);
    chk_reg16("x16_add_wrap", 3, 32'h0000_0000);
    chk_reg16("x16_mul_low", 6, 32'h0000_0000);
    chk_reg16("x16_sub_wrap", 7, 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips32_pipe_core.md
# mips32_pipe_core

Single-clock, parametrised five-stage (IF/ID/EX/MEM/WB) MIPS32-subset core. It is the successor to the two-phase `pipe_MIPS32`. It adds the following:
- hardware hazard interlock;
- optional operand forwarding;
- branch flush;
- asynchronous reset;
- a program-load port;
- a retired-instruction counter.

It is the CPU block for system-level programs; benches load instruction memory through the port or hierarchically.

## Interface
- `XLEN`, 32: datapath and register width, 16..32.
- `NREG`, 32: architectural registers, power of two, 8..32; register fields use the low log2(NREG) bits.
- `IMEM_DEPTH`, 1024: instruction words, power of two.
- `DMEM_DEPTH`, 1024: data words of XLEN, power of two.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `imem_we` in 1: instruction memory write strobe.
- `imem_waddr` in log2(IMEM_DEPTH): write address.
- `imem_wdata` in 32: instruction word.
- `dbg_raddr` in log2(NREG): register debug read address.
- `dbg_rdata` out XLEN: combinational register read; R0 reads 0.
- `pc` out log2(IMEM_DEPTH): current fetch PC.
- `halted` out 1: sticky, set when HLT retires.
- `instret` out 32: count of retired non-bubble instructions, wraps.

## Operation
- Encoding: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0]; imm is sign-extended to XLEN.
- Opcodes:
  - RR: ADD 00, SUB 01, AND 02, OR 03, SLT 04, MUL 05 (rd ← rs op rt).
  - RM: LW 08, SW 09, ADDI 0A, SUBI 0B, SLTI 0C (rt ← rs op imm).
  - Branch: BNEQZ 0D, BEQZ 0E.
  - HLT 3F.
  - Other opcodes decode as bubbles and are not counted.
- Arithmetic:
  - Results wrap modulo 2^XLEN; MUL keeps the low XLEN bits.
  - SLT and SLTI compare signed and produce 1 or 0.
  - LW/SW address is ALU result (rs + imm) modulo DMEM_DEPTH.
- Register file:
  - Writes occur at the end of WB; writes to R0 are dropped.
  - ID reads are write-through, so a same-cycle WB write is visible.
  - Registers and memories have no reset.
- Branches:
  - Resolved in EX on rs == 0.
  - When taken: PC ← NPC + imm (NPC = PC+1, modulo IMEM_DEPTH), and IF/ID and ID/EX are flushed to bubbles (2-cycle penalty).
  - Not taken: no penalty.
- Hazard stall: PC and IF/ID hold, and a bubble is inserted into ID/EX.
- HLT:
  - Fetch freezes while HLT occupies IF/ID or ID/EX.
  - A flush removing that HLT unfreezes fetch.
  - When HLT reaches WB, `halted` is set; the pipeline drains and holds until reset.
- Memory writes: `imem_we` writes at the clock edge at any time; consistency with in-flight fetch is the loader's responsibility.

## Timing
- Reset values:
  - `pc` = 0, `halted` = 0, `instret` = 0.
  - All pipeline registers are bubbles; `dbg_rdata` follows registers.
- Reset mid-run aborts all in-flight instructions immediately and restarts from PC 0 after release.
- Pipeline timing:
  - First fetch happens at the first rising edge after `rst_n` deasserts.
  - An instruction fetched at edge k writes back at edge k+4.
  - Throughput is one instruction per cycle absent hazards.
- A program of N independent instructions followed by HLT sets `halted` at edge N+5 and `instret` = N+1.
- Simultaneous stall and taken branch: the flush wins; PC takes the target.

## Configuration
- `MIPS_FWD_EN` defined:
  - EX/MEM and MEM/WB results forward to EX operands, branch condition and SW data; the youngest writer has priority.
  - Only load-use stalls remain: LW in ID/EX with a matching source in ID gives 1 stall cycle.
- `MIPS_FWD_EN` undefined:
  - ID stalls while ID/EX or EX/MEM holds a writer of a source register other than R0.
  - A back-to-back dependence costs 2 stall cycles.
- Architectural results are identical in both builds; only cycle counts differ.

## Test plan
- R2=6, R3=4; program ADD R5,R2,R3; SUB R7,R5,R3; MUL R9,R7,R3; HLT.
  - Required: R5=10, R7=6, R9=24.
  - `halted` at edge 8 with FWD, edge 12 without; `instret`=4.
- ADDI R11,R2,3; SLTI R13,R2,3; SLTI R14,R0,-1; HLT with R2=6 → R11=9, R13=0, R14=0; ADDI R0,R0,5 leaves R0=0.
- SW R3,1(R0); LW R4,1(R0); ADD R6,R4,R4; HLT with R3=4 → R6=8 and exactly 1 stall cycle with FWD.
- Loop: R1=3; SUBI R1,R1,1; BNEQZ R1,-2; HLT placed after → R1=0, `instret`=7, HLT behind each taken branch flushed without setting `halted`.
- XLEN=16: ADD of 0xFFFF+0x0001 → 0x0000; MUL 0x0100*0x0100 → 0x0000.
- Assert `rst_n` low for 1 cycle mid-loop → `pc`=0, `instret`=0, `halted`=0 immediately; the program reruns to the same final state.
